// File: rtl/dc_motor_pwm_multi.sv
// dc_motor_pwm_multi: multi-channel DC motor PWM driver.
// Debounced inc/dec buttons edit a per-channel target duty. The applied duty
// slews toward that target once per PWM period. A direction change first
// ramps the channel to zero duty, then flips dir_out. The shared nsleep line
// drops after a run of fully idle periods.
module dc_motor_pwm_multi #(
   parameter int CH            = 2,
   parameter int DW            = 8,
   parameter int STEP          = 16,
   parameter int RAMP_STEP     = 4,
   parameter int DEB           = 4,
   parameter int SLEEP_PERIODS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    inc,
   input  logic [CH-1:0]    dec,
   input  logic [CH-1:0]    dir_req,
   output logic [CH-1:0]    pwm_out,
   output logic [CH-1:0]    dir_out,
   output logic [CH*DW-1:0] duty_out,
   output logic [CH-1:0]    busy,
   output logic             nsleep
);

   localparam int NB  = 2 * CH;
   localparam int DCW = $clog2(DEB + 1);
   localparam int SW  = $clog2(SLEEP_PERIODS + 1);

   localparam logic [DW-1:0]  ZERO_D    = {DW{1'b0}};
   localparam logic [DW-1:0]  DUTY_MAX  = {DW{1'b1}};
   localparam logic [DW-1:0]  CNT_LAST  = DUTY_MAX - {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]  RAMP      = DW'(RAMP_STEP);
   localparam logic [DW:0]    STEP_X    = (DW+1)'(STEP);
   localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB - 1);
   localparam logic [SW-1:0]  IDLE_LAST = SW'(SLEEP_PERIODS - 1);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_STOP = 1'b1
   } state_t;

   // Target + STEP computed one bit wider, clamped at full scale.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a);
      logic [DW:0] s;
      s = {1'b0, a} + STEP_X;
      if (s > {1'b0, DUTY_MAX}) sat_add = DUTY_MAX;
      else                      sat_add = s[DW-1:0];
   endfunction

   // Target - STEP computed one bit wider; a borrow clamps to zero.
   function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a);
      logic [DW:0] d;
      d = {1'b0, a} - STEP_X;
      if (d[DW]) sat_sub = ZERO_D;
      else       sat_sub = d[DW-1:0];
   endfunction

   // One slew step: move toward goal by at most RAMP.
   function automatic logic [DW-1:0] slew(input logic [DW-1:0] cur, input logic [DW-1:0] goal);
      logic [DW-1:0] diff;
      if (goal > cur) begin
         diff = goal - cur;
         if (diff > RAMP) slew = cur + RAMP;
         else             slew = goal;
      end else begin
         diff = cur - goal;
         if (diff > RAMP) slew = cur - RAMP;
         else             slew = goal;
      end
   endfunction

   logic [NB-1:0]           btn_s;
   logic [NB-1:0]           sync1_r, sync2_r;
   logic [CH-1:0]           dir_sync1_r, dir_sync2_r;
   logic [NB-1:0][DCW-1:0]  deb_cnt_r;
   logic [NB-1:0]           armed_r, evt_r;
   logic [CH-1:0][DW-1:0]   tgt_r, duty_r, duty_nxt_s, goal_s;
   logic [DW-1:0]           cnt_r;
   logic                    boundary_s;
   state_t [CH-1:0]         state_r, state_nxt_s;
   logic [CH-1:0]           dir_r, dir_nxt_s, pwm_r, busy_r;
   logic [SW-1:0]           idle_r;
   logic                    nsleep_r;
   logic                    any_tgt_s, any_duty_s;

   // Bits [CH-1:0] are inc buttons, [2*CH-1:CH] are dec buttons.
   assign btn_s      = {dec, inc};
   assign boundary_s = (cnt_r == ZERO_D);
   assign any_tgt_s  = |tgt_r;
   assign any_duty_s = |duty_r;

   // Two-flop synchronisers for buttons and the direction switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r     <= {NB{1'b0}};
         sync2_r     <= {NB{1'b0}};
         dir_sync1_r <= {CH{1'b0}};
         dir_sync2_r <= {CH{1'b0}};
      end else begin
         sync1_r     <= btn_s;
         sync2_r     <= sync1_r;
         dir_sync1_r <= dir_req;
         dir_sync2_r <= dir_sync1_r;
      end
   end

   // Debounce: while armed, DEB high cycles fire one event and disarm;
   // while disarmed, DEB low cycles rearm without an event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) deb_cnt_r[i] <= {DCW{1'b0}};
         armed_r <= {NB{1'b1}};
         evt_r   <= {NB{1'b0}};
      end else begin
         for (int i = 0; i < NB; i++) begin
            evt_r[i] <= 1'b0;
            if (sync2_r[i] == armed_r[i]) begin
               if (deb_cnt_r[i] == DEB_LAST) begin
                  deb_cnt_r[i] <= {DCW{1'b0}};
                  armed_r[i]   <= ~armed_r[i];
                  evt_r[i]     <= armed_r[i];
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DCW'(1);
               end
            end else begin
               deb_cnt_r[i] <= {DCW{1'b0}};
            end
         end
      end
   end

   // Saturating target update; simultaneous inc and dec cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < CH; n++) tgt_r[n] <= ZERO_D;
      end else begin
         for (int n = 0; n < CH; n++) begin
            if (evt_r[n] && !evt_r[CH+n])      tgt_r[n] <= sat_add(tgt_r[n]);
            else if (evt_r[CH+n] && !evt_r[n]) tgt_r[n] <= sat_sub(tgt_r[n]);
            else                               tgt_r[n] <= tgt_r[n];
         end
      end
   end

   // Shared PWM period counter, 0 .. 2^DW-2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt_r <= ZERO_D;
      else if (cnt_r == CNT_LAST) cnt_r <= ZERO_D;
      else                        cnt_r <= cnt_r + {{(DW-1){1'b0}}, 1'b1};
   end

   // Per-channel next state: slew goal, duty step at boundaries, reversal handling.
   always_comb begin
      state_nxt_s = state_r;
      dir_nxt_s   = dir_r;
      duty_nxt_s  = duty_r;
      goal_s      = tgt_r;
      for (int n = 0; n < CH; n++) begin
         case (state_r[n])
            ST_RUN:  goal_s[n] = tgt_r[n];
            ST_STOP: goal_s[n] = ZERO_D;
            default: goal_s[n] = ZERO_D;
         endcase
         if (boundary_s) duty_nxt_s[n] = slew(duty_r[n], goal_s[n]);
         else            duty_nxt_s[n] = duty_r[n];
         case (state_r[n])
            ST_RUN: begin
               dir_nxt_s[n] = dir_r[n];
               if (dir_sync2_r[n] != dir_r[n]) state_nxt_s[n] = ST_STOP;
               else                            state_nxt_s[n] = ST_RUN;
            end
            ST_STOP: begin
               if (boundary_s && (duty_nxt_s[n] == ZERO_D)) begin
                  state_nxt_s[n] = ST_RUN;
                  // The request may have been withdrawn while stopping.
                  if (dir_sync2_r[n] != dir_r[n]) dir_nxt_s[n] = ~dir_r[n];
                  else                            dir_nxt_s[n] = dir_r[n];
               end else begin
                  state_nxt_s[n] = ST_STOP;
                  dir_nxt_s[n]   = dir_r[n];
               end
            end
            default: begin
               state_nxt_s[n] = ST_RUN;
               dir_nxt_s[n]   = dir_r[n];
            end
         endcase
      end
   end

   // Channel registers; pwm uses the duty being loaded so a new period starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < CH; n++) begin
            state_r[n] <= ST_RUN;
            duty_r[n]  <= ZERO_D;
         end
         dir_r  <= {CH{1'b0}};
         pwm_r  <= {CH{1'b0}};
         busy_r <= {CH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         dir_r   <= dir_nxt_s;
         duty_r  <= duty_nxt_s;
         for (int n = 0; n < CH; n++) begin
            pwm_r[n]  <= (cnt_r < duty_nxt_s[n]);
            busy_r[n] <= (state_nxt_s[n] == ST_STOP);
         end
      end
   end

   // Driver enable: wake on any target, sleep after SLEEP_PERIODS idle boundaries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nsleep_r <= 1'b0;
         idle_r   <= {SW{1'b0}};
      end else if (any_tgt_s) begin
         nsleep_r <= 1'b1;
         idle_r   <= {SW{1'b0}};
      end else if (boundary_s) begin
         if (any_duty_s) begin
            idle_r   <= {SW{1'b0}};
            nsleep_r <= nsleep_r;
         end else if (idle_r == IDLE_LAST) begin
            idle_r   <= idle_r;
            nsleep_r <= 1'b0;
         end else begin
            idle_r   <= idle_r + SW'(1);
            nsleep_r <= nsleep_r;
         end
      end else begin
         idle_r   <= idle_r;
         nsleep_r <= nsleep_r;
      end
   end

   assign pwm_out  = pwm_r;
   assign dir_out  = dir_r;
   assign duty_out = duty_r;
   assign busy     = busy_r;
   assign nsleep   = nsleep_r;

endmodule

// File: tb/tb_dc_motor_pwm_multi.sv
// Self-checking bench for dc_motor_pwm_multi (CH=2, DW=8, STEP=16, RAMP_STEP=4).
module tb_dc_motor_pwm_multi;

   localparam int CH  = 2;
   localparam int DW  = 8;
   localparam int DEB = 4;
   localparam int PER = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CH-1:0]    inc = '0;
   logic [CH-1:0]    dec = '0;
   logic [CH-1:0]    dir_req = '0;
   logic [CH-1:0]    pwm_out, dir_out, busy;
   logic [CH*DW-1:0] duty_out;
   logic             nsleep;

   dc_motor_pwm_multi #(.CH(CH), .DW(DW), .STEP(16), .RAMP_STEP(4), .DEB(DEB),
                        .SLEEP_PERIODS(4)) dut (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .dir_req(dir_req),
      .pwm_out(pwm_out), .dir_out(dir_out), .duty_out(duty_out),
      .busy(busy), .nsleep(nsleep));

   always #5 clk = ~clk;

   // Bench-side period position, used only to find boundary edges.
   int bcnt;
   always @(posedge clk or posedge rst) begin
      if (rst)              bcnt <= 0;
      else if (bcnt == PER-1) bcnt <= 0;
      else                  bcnt <= bcnt + 1;
   end

   typedef struct { string name; logic [CH-1:0] iv; logic [CH-1:0] dv; int hold; int t0; int t1; } vec_t;
   typedef struct { string name; int t0; int t1; } exp_t;

   exp_t sb_q[$];
   vec_t vecs[7];
   int   checks   = 0;
   int   failures = 0;
   int   m0, m1, d0, hi0, hi1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int duty_of(input int n);
      return int'(duty_out[n*DW +: DW]);
   endfunction

   // Returns #1 after the next edge at which the counter sat at 0.
   task automatic wait_boundary();
      int n;
      n = 0;
      @(negedge clk);
      while (bcnt != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [CH-1:0] iv, input logic [CH-1:0] dv, input int hold);
      @(negedge clk);
      inc = iv;
      dec = dv;
      repeat (hold) @(negedge clk);
      inc = '0;
      dec = '0;
      repeat (2 + DEB + 4) @(negedge clk);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_empty: actual=none required=entry");
      end else begin
         e = sb_q.pop_front();
         chk({e.name, "_tgt0"}, int'(dut.tgt_r[0]), e.t0);
         chk({e.name, "_tgt1"}, int'(dut.tgt_r[1]), e.t1);
      end
   endtask

   task automatic press_expect(input string name, input logic [CH-1:0] iv, input logic [CH-1:0] dv,
                               input int hold, input int e0, input int e1);
      sb_q.push_back('{name, e0, e1});
      press(iv, dv, hold);
      sb_check();
   endtask

   task automatic count_high(output int h0, output int h1);
      h0 = 0;
      h1 = 0;
      repeat (PER) begin
         @(negedge clk);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"glitch3",     2'b01, 2'b00, 3, 16, 0};
      vecs[1] = '{"inc_dec_same", 2'b01, 2'b01, 8, 16, 0};
      vecs[2] = '{"dec1_floor",  2'b00, 2'b10, 8, 16, 0};
      vecs[3] = '{"inc1",        2'b10, 2'b00, 8, 16, 16};
      vecs[4] = '{"dec1",        2'b00, 2'b10, 8, 16, 0};
      vecs[5] = '{"inc0",        2'b01, 2'b00, 8, 32, 0};
      vecs[6] = '{"dec0",        2'b00, 2'b01, 8, 16, 0};

      // Reset held with inc0 pressed.
      rst = 1'b1;
      inc = 2'b01;
      repeat (10) @(negedge clk);
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_dir", int'(dir_out), 0);
      chk("rst_duty", int'(duty_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_nsleep", int'(nsleep), 0);
      chk("rst_tgt0", int'(dut.tgt_r[0]), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_evt_tgt0", int'(dut.tgt_r[0]), 16);
      chk("rst_evt_tgt1", int'(dut.tgt_r[1]), 0);
      chk("rst_evt_nsleep", int'(nsleep), 1);
      repeat (20) @(negedge clk);
      chk("rst_hold_one_evt", int'(dut.tgt_r[0]), 16);
      inc = '0;
      repeat (12) @(negedge clk);

      // Ramp of the first press.
      for (int i = 1; i <= 4; i++) begin
         wait_boundary();
         chk("ramp_duty0", duty_of(0), 4 * i);
         chk("ramp_duty1", duty_of(1), 0);
      end
      wait_boundary();
      count_high(hi0, hi1);
      chk("pwm0_high16", hi0, 16);
      chk("pwm1_low", hi1, 0);

      // Table-driven press vectors.
      for (int v = 0; v < 7; v++)
         press_expect(vecs[v].name, vecs[v].iv, vecs[v].dv, vecs[v].hold, vecs[v].t0, vecs[v].t1);

      // Reversal from duty 64 on ch0, from duty 0 on ch1.
      m0 = 16;
      for (int i = 0; i < 3; i++) begin
         m0 += 16;
         press_expect("rev_inc0", 2'b01, 2'b00, 8, m0, 0);
      end
      for (int k = 0; k < 30; k++) begin
         if (duty_of(0) == 64) break;
         wait_boundary();
      end
      chk("rev_pre_duty0", duty_of(0), 64);
      @(negedge clk);
      dir_req = 2'b11;
      repeat (6) @(negedge clk);
      chk("rev_busy0", int'(busy[0]), 1);
      chk("rev_busy1", int'(busy[1]), 1);
      for (int i = 1; i <= 16; i++) begin
         wait_boundary();
         chk("rev_duty0", duty_of(0), 64 - 4 * i);
         chk("rev_dir0", int'(dir_out[0]), (i == 16) ? 1 : 0);
         chk("rev_busy0_run", int'(busy[0]), (i == 16) ? 0 : 1);
         if (i == 1) begin
            chk("rev_dir1_zero", int'(dir_out[1]), 1);
            chk("rev_busy1_zero", int'(busy[1]), 0);
         end
      end
      repeat (16) wait_boundary();
      chk("rev_back_duty0", duty_of(0), 64);
      chk("rev_back_busy0", int'(busy[0]), 0);
      chk("rev_back_dir0", int'(dir_out[0]), 1);

      // Sleep after four all-idle boundaries.
      for (int i = 0; i < 4; i++) begin
         m0 -= 16;
         press_expect("sleep_dec0", 2'b00, 2'b01, 8, m0, 0);
      end
      for (int k = 0; k < 30; k++) begin
         if (duty_of(0) == 0) break;
         wait_boundary();
      end
      chk("sleep_duty0", duty_of(0), 0);
      for (int k = 1; k <= 4; k++) begin
         wait_boundary();
         chk("sleep_nsleep", int'(nsleep), (k < 4) ? 1 : 0);
      end

      // Saturation with 17 presses.
      m0 = 0;
      m1 = 0;
      for (int i = 0; i < 17; i++) begin
         m0 = (m0 + 16 > 255) ? 255 : m0 + 16;
         press_expect("sat_inc0", 2'b01, 2'b00, 8, m0, m1);
      end
      chk("sat_nsleep", int'(nsleep), 1);
      for (int k = 0; k < 80; k++) begin
         if (duty_of(0) == 255) break;
         wait_boundary();
      end
      chk("sat_duty0", duty_of(0), 255);
      wait_boundary();
      count_high(hi0, hi1);
      chk("sat_pwm0_const", hi0, 255);
      chk("sat_pwm1_low", hi1, 0);

      // Down to 15, then one more dec must floor at 0.
      for (int i = 0; i < 15; i++) begin
         m0 = (m0 - 16 < 0) ? 0 : m0 - 16;
         press_expect("dec_to15", 2'b00, 2'b01, 8, m0, m1);
      end
      chk("tgt_at15", m0, 15);
      press_expect("dec_floor", 2'b00, 2'b01, 8, 0, 0);
      wait_boundary();
      d0 = duty_of(0);
      wait_boundary();
      chk("no_wrap_ramp_down", duty_of(0), d0 - 4);

      // Asynchronous reset in the middle of the ramp.
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_pwm", int'(pwm_out), 0);
      chk("arst_duty", int'(duty_out), 0);
      chk("arst_dir", int'(dir_out), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_nsleep", int'(nsleep), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
